// File: rtl/opera_bus_pkg.sv
// Shared types and constants for the opera bus controller and its decoder.
package opera_bus_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_REG_STB  = 3'd1;
   localparam state_t ST_REG_WAIT = 3'd2;
   localparam state_t ST_EXT_WAIT = 3'd3;
   localparam state_t ST_DONE     = 3'd4;

   typedef enum logic [1:0] {
      SLV_MADAM = 2'd0,
      SLV_CLIO  = 2'd1,
      SLV_EXT   = 2'd2
   } slave_e;

   localparam logic [31:0] MADAM_BASE_DEF = 32'h0330_0000;
   localparam logic [31:0] CLIO_BASE_DEF  = 32'h0340_0000;
   localparam logic [31:0] TIMEOUT_FILL   = 32'hDEAD_BEEF;

   // Register windows are 64 KiB, so only the upper half-word identifies them.
   function automatic logic in_window(input logic [31:0] adr, input logic [31:0] base);
      return adr[31:16] == base[31:16];
   endfunction

endpackage

// File: rtl/opera_addr_decode.sv
// Combinational address to slave-select decode for the MADAM / CLIO / external map.
module opera_addr_decode
   import opera_bus_pkg::*;
#(
   parameter logic [31:0] MADAM_BASE = MADAM_BASE_DEF,
   parameter logic [31:0] CLIO_BASE  = CLIO_BASE_DEF
)(
   input  logic [31:0] adr,
   output slave_e      slave
);

   always_comb begin
      slave = SLV_EXT;
      if (in_window(adr, MADAM_BASE)) begin
         slave = SLV_MADAM;
      end else if (in_window(adr, CLIO_BASE)) begin
         slave = SLV_CLIO;
      end
   end

endmodule

// File: rtl/opera_bus_arb.sv
// Two-master, three-slave bus controller: round-robin arbitration, register strobes, ext Wishbone.
// Define OPERA_BUS_TIMEOUT_EN to force completion of external cycles that never see ext_ack.
//
// state       | meaning
// ST_IDLE     | no transaction; arbitrate and latch the winner's request
// ST_REG_STB  | single-cycle register strobe, register read data captured
// ST_REG_WAIT | register wait states counting down
// ST_EXT_WAIT | ext_stb held until ext_ack (or timeout when enabled)
// ST_DONE     | ack the owner, update last_grant, return to idle
module opera_bus_arb
   import opera_bus_pkg::*;
#(
   parameter int unsigned REG_WAIT   = 1,
   parameter int unsigned TIMEOUT    = 255,
   parameter logic [31:0] MADAM_BASE = MADAM_BASE_DEF,
   parameter logic [31:0] CLIO_BASE  = CLIO_BASE_DEF
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_dat_w,
   input  logic [3:0]  m0_sel,
   output logic [31:0] m0_dat_r,
   output logic        m0_ack,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_dat_w,
   output logic [31:0] m1_dat_r,
   output logic        m1_ack,
   output logic        madam_rd,
   output logic        madam_wr,
   output logic        clio_rd,
   output logic        clio_wr,
   output logic [31:0] reg_adr,
   output logic [31:0] reg_dat_w,
   input  logic [31:0] madam_dat_r,
   input  logic [31:0] clio_dat_r,
   output logic        ext_stb,
   output logic        ext_we,
   output logic [31:0] ext_adr,
   output logic [31:0] ext_dat_w,
   output logic [3:0]  ext_sel,
   input  logic [31:0] ext_dat_r,
   input  logic        ext_ack,
   output logic        grant,
   output logic        busy,
   output logic        err_timeout
);

   localparam logic [15:0] REG_WAIT_CNT = 16'(REG_WAIT);
   localparam logic [15:0] TIMEOUT_CNT  = 16'(TIMEOUT);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   slave_e      slave_q, slave_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] hold_q, hold_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [31:0] m0_dat_q, m0_dat_d;
   logic [31:0] m1_dat_q, m1_dat_d;

   logic        req0, req1, win;
   logic [31:0] win_adr, win_dat;
   logic        win_we;
   logic [3:0]  win_sel;
   slave_e      win_slave;
   logic        done, reg_stb;
   logic [31:0] done_dat;

   assign req0    = m0_cyc & m0_stb;
   assign req1    = m1_req;
   // On a tie the master that did not own the previous transaction wins.
   assign win     = (req0 & req1) ? ~last_q : req1;
   assign win_adr = win ? m1_adr   : m0_adr;
   assign win_dat = win ? m1_dat_w : m0_dat_w;
   assign win_we  = win ? m1_we    : m0_we;
   assign win_sel = win ? 4'hF     : m0_sel;

   opera_addr_decode #(
      .MADAM_BASE (MADAM_BASE),
      .CLIO_BASE  (CLIO_BASE)
   ) u_decode (
      .adr   (win_adr),
      .slave (win_slave)
   );

   // Pulses are gated by i_reset so a reset cycle never leaks a strobe or ack.
   assign done     = (state_q == ST_DONE) & ~i_reset;
   assign reg_stb  = (state_q == ST_REG_STB) & ~i_reset;
   assign done_dat = we_q ? 32'h0 : hold_q;

   assign m0_ack   = done & ~owner_q & m0_cyc;
   assign m1_ack   = done & owner_q;
   assign m0_dat_r = m0_ack ? done_dat : m0_dat_q;
   assign m1_dat_r = m1_ack ? done_dat : m1_dat_q;

   assign madam_rd = reg_stb & (slave_q == SLV_MADAM) & ~we_q;
   assign madam_wr = reg_stb & (slave_q == SLV_MADAM) &  we_q;
   assign clio_rd  = reg_stb & (slave_q == SLV_CLIO)  & ~we_q;
   assign clio_wr  = reg_stb & (slave_q == SLV_CLIO)  &  we_q;

   assign reg_adr     = adr_q;
   assign reg_dat_w   = wdat_q;
   assign ext_adr     = adr_q;
   assign ext_dat_w   = wdat_q;
   assign ext_we      = we_q;
   assign ext_sel     = sel_q;
   assign ext_stb     = (state_q == ST_EXT_WAIT) & ~i_reset;
   assign grant       = owner_q;
   assign busy        = state_q != ST_IDLE;
   assign err_timeout = err_q & ~i_reset;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      slave_d  = slave_q;
      we_d     = we_q;
      adr_d    = adr_q;
      wdat_d   = wdat_q;
      sel_d    = sel_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      m0_dat_d = m0_dat_q;
      m1_dat_d = m1_dat_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 | req1) begin
               owner_d = win;
               slave_d = win_slave;
               we_d    = win_we;
               adr_d   = win_adr;
               wdat_d  = win_dat;
               sel_d   = win_sel;
               cnt_d   = TIMEOUT_CNT;
               state_d = (win_slave == SLV_EXT) ? ST_EXT_WAIT : ST_REG_STB;
            end
         end
         ST_REG_STB: begin
            hold_d = (slave_q == SLV_MADAM) ? madam_dat_r : clio_dat_r;
            if (REG_WAIT_CNT == 16'd0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d   = REG_WAIT_CNT;
               state_d = ST_REG_WAIT;
            end
         end
         ST_REG_WAIT: begin
            if (cnt_q <= 16'd1) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_EXT_WAIT: begin
            if (ext_ack) begin
               hold_d  = ext_dat_r;
               state_d = ST_DONE;
            end
`ifdef OPERA_BUS_TIMEOUT_EN
            else if (cnt_q <= 16'd1) begin
               hold_d  = TIMEOUT_FILL;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
`endif
         end
         ST_DONE: begin
            last_d  = owner_q;
            state_d = ST_IDLE;
            if (m0_ack) m0_dat_d = done_dat;
            if (m1_ack) m1_dat_d = done_dat;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         slave_q  <= SLV_MADAM;
         we_q     <= 1'b0;
         adr_q    <= 32'h0;
         wdat_q   <= 32'h0;
         sel_q    <= 4'h0;
         hold_q   <= 32'h0;
         cnt_q    <= 16'h0;
         err_q    <= 1'b0;
         m0_dat_q <= 32'h0;
         m1_dat_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         slave_q  <= slave_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         wdat_q   <= wdat_d;
         sel_q    <= sel_d;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         m0_dat_q <= m0_dat_d;
         m1_dat_q <= m1_dat_d;
      end
   end

endmodule

// File: doc/opera_bus_arb.md
Name: opera_bus_arb

Overview:
- Two-master, three-slave bus controller between the ZAP CPU's Wishbone port (M0) and a DMA/engine requester (M1).
- Slaves: MADAM register window, CLIO register window, external memory (BIOS/DRAM/VRAM, sim-backed).
- Decodes addresses, arbitrates round-robin, generates register-slave acks with programmable wait states, muxes read data back to the owning master.
- Replaces the free-running combinational chip-select/read-mux in core_3do.

Parameters:
- REG_WAIT, 1, extra cycles between register strobe and ack (0..15).
- TIMEOUT, 255, max cycles waiting for ext_ack before forced completion (1..65535).
- MADAM_BASE, 32'h0330_0000, MADAM window base; window is 64 KiB.
- CLIO_BASE, 32'h0340_0000, CLIO window base; window is 64 KiB.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous reset, active high
- m0_cyc, m0_stb, m0_we  in  1  CPU Wishbone classic controls
- m0_adr, m0_dat_w  in  32  CPU address / write data
- m0_sel  in  4  CPU byte selects
- m0_dat_r  out  32  read data to CPU
- m0_ack  out  1  ack to CPU
- m1_req, m1_we  in  1  DMA request (held until ack) / write
- m1_adr, m1_dat_w  in  32  DMA address / write data (m1 sel fixed 4'hF)
- m1_dat_r  out  32  read data to DMA
- m1_ack  out  1  ack to DMA
- madam_rd, madam_wr, clio_rd, clio_wr  out  1  single-cycle register strobes
- reg_adr, reg_dat_w  out  32  register-slave address / write data
- madam_dat_r, clio_dat_r  in  32  register read data, valid while strobe is high
- ext_stb, ext_we  out  1  external-slave Wishbone controls
- ext_adr, ext_dat_w  out  32  external address / write data
- ext_sel  out  4  external byte selects
- ext_dat_r  in  32  external read data
- ext_ack  in  1  external ack
- grant  out  1  current owner (0=CPU, 1=DMA), valid when busy
- busy  out  1  transaction in flight
- err_timeout  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset: state IDLE; all outputs 0; last_grant=1, so the CPU wins the first tie.
- Requests: M0 is active when m0_cyc&m0_stb; M1 is active when m1_req.
- Decode (registered at grant):
  - MADAM if adr[31:16]==MADAM_BASE[31:16].
  - CLIO if adr[31:16]==CLIO_BASE[31:16].
  - Otherwise EXT.
- FSM states: IDLE, REG_STB, REG_WAIT, EXT_WAIT, DONE.
- IDLE:
  - If any request: grant the sole requester; on a tie, grant the master not in last_grant.
  - Latch adr/dat/we/sel/slave; busy=1.
  - Go to REG_STB (register slave) or EXT_WAIT with ext_stb=1 (external).
- REG_STB:
  - Assert exactly one of madam_rd/madam_wr/clio_rd/clio_wr for one cycle.
  - Capture the selected dat_r into the holding register.
  - REG_WAIT==0: go to DONE. Otherwise go to REG_WAIT with counter=REG_WAIT.
- REG_WAIT: decrement the counter; go to DONE when it reaches 1.
  - Register latency from grant: 2+REG_WAIT cycles to ack.
- EXT_WAIT:
  - Hold ext_stb and latched fields.
  - On ext_ack: capture ext_dat_r, drop ext_stb, go to DONE.
  - Timeout counter: see Optional Feature.
- DONE:
  - Pulse the owner's ack for one cycle with dat_r from the holding register; other master's ack stays 0.
  - Update last_grant; busy=0; go to IDLE.
  - The owner's stb/req is ignored in this cycle, giving one idle cycle minimum between back-to-back transactions.
- Read data: held on m*_dat_r until the next ack to that master. Write transactions return 0.
- Master withdraws mid-transaction (m0_cyc low): transaction still completes on the slave. Ack is suppressed if the master's cyc is low in DONE.
- i_reset mid-transaction: immediate return to IDLE; ext_stb drops the same cycle; no ack is issued.
- Simultaneous ext_ack and timeout expiry: ext_ack wins; no err_timeout.

Optional Feature:
- OPERA_BUS_TIMEOUT_EN defined:
  - EXT_WAIT counts cycles.
  - After TIMEOUT cycles without ext_ack: drop ext_stb, load 32'hDEAD_BEEF into the holding register, pulse err_timeout, go to DONE.
- Undefined:
  - No counter; EXT_WAIT waits indefinitely.
  - err_timeout tied 0.

Decomposition:
- Package opera_bus_pkg:
  - State encoding enum.
  - Slave-select enum (SLV_MADAM, SLV_CLIO, SLV_EXT).
  - Default window bases.
  - Timeout fill constant 32'hDEAD_BEEF.
- One sub-module, opera_addr_decode: combinational address -> slave-select, parameterised by window bases; reused by the bench's reference model.

Test Plan:
- CPU reads 32'h0330_0004, madam_dat_r=32'h1234_5678, REG_WAIT=1 -> madam_rd one cycle; m0_ack 3 cycles after grant; m0_dat_r=32'h1234_5678.
- CPU writes 32'hCAFE_0001 to 32'h0340_0020 -> clio_wr one cycle; reg_adr=32'h0340_0020; reg_dat_w=32'hCAFE_0001; no madam strobes.
- CPU and DMA both request ext addresses continuously -> grants alternate CPU, DMA, CPU, DMA; exactly one ack per transaction.
- External read 32'h0000_1000, ext_ack after 5 cycles with ext_dat_r=32'hA5A5_A5A5 -> ext_stb high 5 cycles; m0_dat_r=32'hA5A5_A5A5.
- With OPERA_BUS_TIMEOUT_EN, TIMEOUT=8, ext_ack never asserted -> err_timeout pulse after 8 cycles; m0_ack with dat_r=32'hDEAD_BEEF.
- i_reset asserted during EXT_WAIT -> next cycle: busy=0, ext_stb=0, no ack; a new request is accepted normally afterwards.
